// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter:
// FSM state encoding and default bus widths.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin grant: a lone requester always wins,
// contention goes to the port named by i_prio.
module sdram_arb_rr (
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = i_prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single SDRAM controller; one transaction
// outstanding at a time, round-robin fairness, sticky timeout flag.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_rvalid,

    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_rvalid,

    output logic              mem_in_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_out_valid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_timeout;
    logic              w_capture;
    logic              w_read_done;
    logic [DATA_W-1:0] w_ret_data;

    logic              r_port;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cap;
    logic              r_got;
    logic              r_prio;
    logic              r_err;
    logic [CNT_W-1:0]  r_tcnt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    assign w_valid = {req1_valid, req0_valid};

    sdram_arb_rr u_rr (
        .i_valid (w_valid),
        .i_prio  (r_prio),
        .o_grant (w_grant)
    );

    assign w_accept    = (r_state == IDLE) && (w_valid != 2'b00);
    assign w_timeout   = (r_state == ISSUE) && !mem_busy && (r_tcnt == CNT_W'(TIMEOUT - 1));
    assign w_capture   = ((r_state == ISSUE) || (r_state == WAIT_BUSY)) && !r_rw && mem_out_valid;
    assign w_read_done = (r_state == WAIT_BUSY) && !r_rw && !mem_busy && (r_got || mem_out_valid);
    assign w_ret_data  = mem_out_valid ? mem_rdata : r_cap;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = ISSUE;
            ISSUE: begin
                if (mem_busy)       w_next = WAIT_BUSY;
                else if (w_timeout) w_next = IDLE;
            end
            // A read also needs its data before it may finish.
            WAIT_BUSY: if (!mem_busy && (r_rw || r_got || mem_out_valid)) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        req0_rvalid  = 1'b0;
        req1_rvalid  = 1'b0;
        mem_in_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_grant[0] && !reset;
                req1_ready = w_grant[1] && !reset;
            end
            ISSUE: mem_in_valid = 1'b1;
            DONE: begin
                req0_rvalid = !r_rw && !r_port;
                req1_rvalid = !r_rw &&  r_port;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port   <= 1'b0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cap    <= '0;
            r_got    <= 1'b0;
            r_prio   <= 1'b0;
            r_err    <= 1'b0;
            r_tcnt   <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_accept) begin
                r_port  <= w_grant[1];
                r_rw    <= w_grant[1] ? req1_rw    : req0_rw;
                r_addr  <= w_grant[1] ? req1_addr  : req0_addr;
                r_wdata <= w_grant[1] ? req1_wdata : req0_wdata;
                r_got   <= 1'b0;
            end

            if (r_state == ISSUE) r_tcnt <= r_tcnt + CNT_W'(1);
            else                  r_tcnt <= '0;

            if (w_timeout) r_err <= 1'b1;

            if (w_capture) begin
                r_cap <= mem_rdata;
                r_got <= 1'b1;
            end

            // Load the returning port's data so it is valid during the DONE pulse.
            if (w_read_done) begin
                if (r_port) r_rdata1 <= w_ret_data;
                else        r_rdata0 <= w_ret_data;
            end

            if (r_state == DONE) r_prio <= ~r_port;
        end
    end

    assign mem_rw     = r_rw;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;
    assign err        = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected grants/commands and read returns
// are queued as stimulus is issued and matched when the DUT produces them.
module tb_sdram_arbiter;

    localparam int AW = 22;
    localparam int DW = 16;

    typedef struct {
        int          port;
        logic        rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_rw = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_rw = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          mem_in_valid, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_busy = 1'b0, mem_out_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          err;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            grant_cyc = 0;
    int            iv_cycles = 0;
    logic          prev_iv = 1'b0;
    logic          ctl_en = 1'b1;
    logic [DW-1:0] ctl_rdata = '0;
    logic          c_rw;
    logic [DW-1:0] exp_rdata [2] = '{default: '0};

    cmd_t q_cmd[$];
    rd_t  q_rd[$];
    cmd_t cur;
    rd_t  e;

    sdram_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_rw       (req0_rw),
        .req0_addr     (req0_addr),
        .req0_wdata    (req0_wdata),
        .req0_ready    (req0_ready),
        .req0_rdata    (req0_rdata),
        .req0_rvalid   (req0_rvalid),
        .req1_valid    (req1_valid),
        .req1_rw       (req1_rw),
        .req1_addr     (req1_addr),
        .req1_wdata    (req1_wdata),
        .req1_ready    (req1_ready),
        .req1_rdata    (req1_rdata),
        .req1_rvalid   (req1_rvalid),
        .mem_in_valid  (mem_in_valid),
        .mem_rw        (mem_rw),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_busy      (mem_busy),
        .mem_out_valid (mem_out_valid),
        .mem_rdata     (mem_rdata),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        cmd_t c;
        c.port = p; c.rw = rw; c.addr = a; c.wdata = wd;
        q_cmd.push_back(c);
    endtask

    task automatic push_rd(input int p, input logic [DW-1:0] d);
        rd_t r;
        r.port = p; r.data = d;
        q_rd.push_back(r);
    endtask

    // Raise a request, wait (bounded) for its ready pulse, then drop it.
    task automatic do_req(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic got = 1'b0;
        @(posedge clk); #1;
        if (p == 0) begin req0_valid = 1'b1; req0_rw = rw; req0_addr = a; req0_wdata = wd; end
        else        begin req1_valid = 1'b1; req1_rw = rw; req1_addr = a; req1_wdata = wd; end
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        if (!got) check("ready_timeout", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  {req1_ready, req0_ready}, 0);
        check({tag, "_rvalid"}, {req1_rvalid, req0_rvalid}, 0);
        check({tag, "_in_valid"}, mem_in_valid, 0);
        check({tag, "_mem_rw"}, mem_rw, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rdata"}, {req1_rdata, req0_rdata}, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Controller model: busy the cycle after a command, two busy cycles, then a
    // one-cycle data return for reads before busy drops.
    always begin
        @(negedge clk);
        if (ctl_en && mem_in_valid && !reset) begin
            c_rw = mem_rw;
            @(posedge clk); #1 mem_busy = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            if (!c_rw) begin
                mem_out_valid = 1'b1;
                mem_rdata = ctl_rdata;
                @(posedge clk); #1;
                mem_out_valid = 1'b0;
            end
            mem_busy = 1'b0;
        end
    end

    // Monitors: grants, issued commands, read returns.
    always @(negedge clk) begin
        if (reset) begin
            prev_iv = 1'b0;
        end else begin
            if (req0_ready || req1_ready) begin
                check("ready_onehot", req0_ready & req1_ready, 0);
                if (q_cmd.size() == 0) begin
                    check("unexpected_ready", {req1_ready, req0_ready}, 0);
                end else begin
                    cur = q_cmd.pop_front();
                    check("grant_port", req1_ready ? 1 : 0, cur.port);
                    grant_cyc = cyc;
                end
            end
            if (mem_in_valid && !prev_iv) begin
                check("issue_latency", cyc - grant_cyc, 1);
                check("mem_rw", mem_rw, cur.rw);
                check("mem_addr", mem_addr, cur.addr);
                check("mem_wdata", mem_wdata, cur.wdata);
            end
            prev_iv = mem_in_valid;
            if (mem_in_valid) iv_cycles++;
            if (req0_rvalid || req1_rvalid) begin
                if (q_rd.size() == 0) begin
                    check("unexpected_rvalid", {req1_rvalid, req0_rvalid}, 0);
                end else begin
                    e = q_rd.pop_front();
                    check("rvalid_port", {req1_rvalid, req0_rvalid}, (e.port == 1) ? 2'b10 : 2'b01);
                    check("rdata", (e.port == 1) ? req1_rdata : req0_rdata, e.data);
                    exp_rdata[e.port] = e.data;
                    check("other_rdata_hold", (e.port == 1) ? req0_rdata : req1_rdata, exp_rdata[1 - e.port]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset = 1'b0;
        settle(2);

        // Contention from reset: port 0 first, then alternation 0,1,0,1
        push_cmd(0, 1'b1, 22'h000100, 16'h1111);
        push_cmd(1, 1'b1, 22'h000200, 16'h2222);
        push_cmd(0, 1'b1, 22'h000101, 16'h3333);
        push_cmd(1, 1'b1, 22'h000201, 16'h4444);
        fork
            begin
                do_req(0, 1'b1, 22'h000100, 16'h1111);
                do_req(0, 1'b1, 22'h000101, 16'h3333);
            end
            begin
                do_req(1, 1'b1, 22'h000200, 16'h2222);
                do_req(1, 1'b1, 22'h000201, 16'h4444);
            end
        join
        settle(20);
        check("contention_drained", q_cmd.size(), 0);

        // Single write from port 0
        push_cmd(0, 1'b1, 22'h000010, 16'hA5A5);
        do_req(0, 1'b1, 22'h000010, 16'hA5A5);
        settle(20);

        // Read from port 1 at the top address
        ctl_rdata = 16'h1234;
        push_cmd(1, 1'b0, 22'h3FFFFF, 16'h0000);
        push_rd(1, 16'h1234);
        do_req(1, 1'b0, 22'h3FFFFF, 16'h0000);
        settle(20);
        check("read1_returned", q_rd.size(), 0);

        // Read from port 0; port 1 data must hold
        ctl_rdata = 16'hBEEF;
        push_cmd(0, 1'b0, 22'h2AAAAA, 16'h0000);
        push_rd(0, 16'hBEEF);
        do_req(0, 1'b0, 22'h2AAAAA, 16'h0000);
        settle(20);

        // Lone requester on the port just served is still granted
        push_cmd(0, 1'b1, 22'h000020, 16'h0F0F);
        do_req(0, 1'b1, 22'h000020, 16'h0F0F);
        settle(20);
        push_cmd(0, 1'b1, 22'h000021, 16'hF0F0);
        do_req(0, 1'b1, 22'h000021, 16'hF0F0);
        settle(20);

        // Controller never goes busy: timeout after 1024 ISSUE cycles, no rvalid
        ctl_en = 1'b0;
        check("err_before_timeout", err, 0);
        iv_cycles = 0;
        push_cmd(1, 1'b0, 22'h000055, 16'h0000);
        do_req(1, 1'b0, 22'h000055, 16'h0000);
        for (int i = 0; i < 1200 && !err; i++) @(negedge clk);
        check("timeout_err", err, 1);
        check("timeout_len", iv_cycles, 1024);
        check("timeout_in_valid_drop", mem_in_valid, 0);
        ctl_en = 1'b1;
        settle(3);

        // Next request after timeout is serviced normally, err stays set
        ctl_rdata = 16'hC0DE;
        push_cmd(1, 1'b0, 22'h000056, 16'h0000);
        push_rd(1, 16'hC0DE);
        do_req(1, 1'b0, 22'h000056, 16'h0000);
        settle(20);
        check("err_sticky", err, 1);

        // Reset in WAIT_BUSY of a read
        ctl_en = 1'b0;
        push_cmd(0, 1'b0, 22'h000123, 16'h0000);
        do_req(0, 1'b0, 22'h000123, 16'h0000);
        mem_busy = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        mem_out_valid = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        check("stale_out_valid_ignored", {req1_rvalid, req0_rvalid}, 0);
        @(posedge clk); #1 mem_out_valid = 1'b0;
        settle(3);
        check("stale_no_rvalid_later", q_rd.size(), 0);
        ctl_en = 1'b1;

        // Normal service after the abandoned transaction
        ctl_rdata = 16'h5A5A;
        push_cmd(1, 1'b0, 22'h000777, 16'h0000);
        push_rd(1, 16'h5A5A);
        do_req(1, 1'b0, 22'h000777, 16'h0000);
        settle(20);

        check("cmd_queue_empty", q_cmd.size(), 0);
        check("rd_queue_empty", q_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
